// File: rtl/access_pkg.sv
// access_pkg: shared encodings for the door-access controller.
//   - state_t: 3-bit controller state; the value doubles as the LCD msg_id.
//   - MSG_*:   msg_id encodings shared with the LCD message ROM.
//   - KEY_*:   keypad codes with special meaning.
package access_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PROFILE   = 3'd1,
        ST_CODE      = 3'd2,
        ST_OPEN      = 3'd3,
        ST_DOOR_OPEN = 3'd4,
        ST_ALARM     = 3'd5,
        ST_HELD      = 3'd6,
        ST_SPARE     = 3'd7
    } state_t;

    localparam logic [2:0] MSG_IDLE      = 3'd0;
    localparam logic [2:0] MSG_PROFILE   = 3'd1;
    localparam logic [2:0] MSG_CODE      = 3'd2;
    localparam logic [2:0] MSG_OPEN      = 3'd3;
    localparam logic [2:0] MSG_DOOR_OPEN = 3'd4;
    localparam logic [2:0] MSG_ALARM     = 3'd5;
    localparam logic [2:0] MSG_HELD      = 3'd6;

    localparam logic [3:0] KEY_STAR        = 4'hE;
    localparam logic [3:0] KEY_HASH        = 4'hF;
    localparam logic [3:0] KEY_LAST_LETTER = 4'hD;

endpackage

// File: rtl/access_timer.sv
// access_timer: shared up-counter with synchronous clear and terminal compare.
// Ports:
//   clk, reset (sync, active-low)
//   clear    - restart from zero (wins over enable)
//   enable   - count one per cycle, saturating at terminal
//   terminal - terminal count value
//   done     - count has reached terminal
module access_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic             done
);

    logic [WIDTH-1:0] count_r;

    assign done = (count_r == terminal);

    // Counter register: clear, count up, hold at terminal.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clear) begin
            count_r <= {WIDTH{1'b0}};
        end else if (enable && !done) begin
            count_r <= count_r + WIDTH'(1);
        end
    end

endmodule

// File: rtl/access_ctrl_fsm.sv
// access_ctrl_fsm: multi-user keypad door-access controller.
// Ports:
//   clk, reset (sync, active-low)
//   key_valid/key_code - keypad strobe and key (0-9, A-D, E='*', F='#')
//   presence           - person within range
//   reed_closed        - door closed
//   unlock, buzz       - servo release, alarm buzzer
//   msg_id             - LCD message select (= state encoding)
//   user_id, digits_entered, tries_left - status counters
// Build option: define FORCED_ENTRY_ALARM_EN to raise ALARM when the door opens
// while in IDLE, PROFILE or CODE.
module access_ctrl_fsm
    import access_pkg::*;
#(
    parameter int N_USERS       = 4,
    parameter int CODE_DIGITS   = 4,
    parameter logic [N_USERS*4*CODE_DIGITS-1:0] USER_CODES = 64'h0000_1234_4693_2580,
    parameter int MAX_TRIES     = 3,
    parameter int ENTRY_TIMEOUT = 50_000_000,
    parameter int OPEN_TIME     = 150_000_000,
    parameter int ALARM_TIME    = 250_000_000,
    localparam int UID_W = (N_USERS > 1) ? $clog2(N_USERS) : 1,
    localparam int DIG_W = $clog2(CODE_DIGITS + 1),
    localparam int TRY_W = $clog2(MAX_TRIES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    input  logic             presence,
    input  logic             reed_closed,
    output logic             unlock,
    output logic             buzz,
    output logic [2:0]       msg_id,
    output logic [UID_W-1:0] user_id,
    output logic [DIG_W-1:0] digits_entered,
    output logic [TRY_W-1:0] tries_left
);

    localparam int BUF_W    = 4 * CODE_DIGITS;
    localparam int MAX_EO   = (ENTRY_TIMEOUT > OPEN_TIME) ? ENTRY_TIMEOUT : OPEN_TIME;
    localparam int MAX_TIME = (MAX_EO > ALARM_TIME) ? MAX_EO : ALARM_TIME;
    localparam int TMR_W    = (MAX_TIME > 1) ? $clog2(MAX_TIME) : 1;

    localparam logic [TMR_W-1:0] ENTRY_TERM = TMR_W'(ENTRY_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] OPEN_TERM  = TMR_W'(OPEN_TIME - 1);
    localparam logic [TMR_W-1:0] ALARM_TERM = TMR_W'(ALARM_TIME - 1);
    localparam logic [DIG_W-1:0] DIG_FULL   = DIG_W'(CODE_DIGITS);
    localparam logic [TRY_W-1:0] TRY_MAX    = TRY_W'(MAX_TRIES);
    localparam logic [TRY_W-1:0] TRY_ONE    = TRY_W'(1);
    localparam logic [3:0]       USER_LIMIT = 4'(N_USERS);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [UID_W-1:0] user_id_r;
    logic             prof_valid_r;
    logic [BUF_W-1:0] code_buf_r;
    logic [DIG_W-1:0] digits_r;
    logic             overflow_r;
    logic [TRY_W-1:0] tries_r;

    logic [TMR_W-1:0] tmr_terminal_s;
    logic             tmr_enable_s;
    logic             tmr_clear_s;
    logic             tmr_done_s;
    logic             timeout_s;
    logic             in_entry_s;
    logic             forced_s;
    logic             key_star_s;
    logic             key_hash_s;
    logic             key_alnum_s;
    logic             profile_key_s;
    logic             submit_s;
    logic             submit_ok_s;
    logic [BUF_W-1:0] user_code_s;

    assign in_entry_s    = (state_r == ST_PROFILE) || (state_r == ST_CODE);
    assign key_star_s    = key_valid && (key_code == KEY_STAR);
    assign key_hash_s    = key_valid && (key_code == KEY_HASH);
    assign key_alnum_s   = key_valid && (key_code <= KEY_LAST_LETTER);
    assign profile_key_s = key_valid && (key_code < USER_LIMIT);
    assign user_code_s   = USER_CODES[int'(user_id_r) * BUF_W +: BUF_W];
    assign submit_ok_s   = (digits_r == DIG_FULL) && !overflow_r && (code_buf_r == user_code_s);

`ifdef FORCED_ENTRY_ALARM_EN
    assign forced_s = !reed_closed &&
                      ((state_r == ST_IDLE) || (state_r == ST_PROFILE) || (state_r == ST_CODE));
`else
    assign forced_s = 1'b0;
`endif

    // A submit only counts when nothing of higher priority takes the cycle.
    assign submit_s  = (state_r == ST_CODE) && key_star_s && !timeout_s && presence && !forced_s;
    assign timeout_s = tmr_enable_s && tmr_done_s;

    // Per-state timer limit; IDLE and HELD hold the timer at zero.
    always_comb begin
        tmr_terminal_s = ENTRY_TERM;
        tmr_enable_s   = 1'b0;
        case (state_r)
            ST_PROFILE, ST_CODE: begin
                tmr_terminal_s = ENTRY_TERM;
                tmr_enable_s   = 1'b1;
            end
            ST_OPEN, ST_DOOR_OPEN: begin
                tmr_terminal_s = OPEN_TERM;
                tmr_enable_s   = 1'b1;
            end
            ST_ALARM: begin
                tmr_terminal_s = ALARM_TERM;
                tmr_enable_s   = 1'b1;
            end
            default: begin
                tmr_terminal_s = ENTRY_TERM;
                tmr_enable_s   = 1'b0;
            end
        endcase
    end

    // Next-state selection: timeout, then presence loss, then keys.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (forced_s)      state_nxt_s = ST_ALARM;
                else if (presence) state_nxt_s = ST_PROFILE;
                else               state_nxt_s = ST_IDLE;
            end
            ST_PROFILE: begin
                if (forced_s)                         state_nxt_s = ST_ALARM;
                else if (timeout_s || !presence)      state_nxt_s = ST_IDLE;
                else if (key_star_s && prof_valid_r)  state_nxt_s = ST_CODE;
                else                                  state_nxt_s = ST_PROFILE;
            end
            ST_CODE: begin
                if (forced_s)                    state_nxt_s = ST_ALARM;
                else if (timeout_s || !presence) state_nxt_s = ST_IDLE;
                else if (submit_s && submit_ok_s) state_nxt_s = ST_OPEN;
                else if (submit_s && (tries_r <= TRY_ONE)) state_nxt_s = ST_ALARM;
                else                             state_nxt_s = ST_CODE;
            end
            ST_OPEN: begin
                if (!reed_closed)   state_nxt_s = ST_DOOR_OPEN;
                else if (timeout_s) state_nxt_s = ST_IDLE;
                else                state_nxt_s = ST_OPEN;
            end
            ST_DOOR_OPEN: begin
                if (reed_closed)    state_nxt_s = ST_IDLE;
                else if (timeout_s) state_nxt_s = ST_HELD;
                else                state_nxt_s = ST_DOOR_OPEN;
            end
            ST_HELD: begin
                if (reed_closed) state_nxt_s = ST_IDLE;
                else             state_nxt_s = ST_HELD;
            end
            ST_ALARM: begin
                if (timeout_s) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_ALARM;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Timer restarts on any state change and on every key while entering.
    assign tmr_clear_s = (state_nxt_s != state_r) || (in_entry_s && key_valid) || !tmr_enable_s;

    access_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmr_clear_s),
        .enable   (tmr_enable_s),
        .terminal (tmr_terminal_s),
        .done     (tmr_done_s)
    );

    // State register plus profile, digit buffer and retry bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            user_id_r    <= {UID_W{1'b0}};
            prof_valid_r <= 1'b0;
            code_buf_r   <= {BUF_W{1'b0}};
            digits_r     <= {DIG_W{1'b0}};
            overflow_r   <= 1'b0;
            tries_r      <= TRY_MAX;
        end else begin
            state_r <= state_nxt_s;

            // A profile must be chosen afresh on every approach.
            if (state_r == ST_IDLE) begin
                prof_valid_r <= 1'b0;
            end else if ((state_r == ST_PROFILE) && (state_nxt_s == ST_PROFILE) && profile_key_s) begin
                user_id_r    <= key_code[UID_W-1:0];
                prof_valid_r <= 1'b1;
            end

            // Buffer lives only while staying in CODE; a failed submit clears it.
            if ((state_r == ST_CODE) && (state_nxt_s == ST_CODE)) begin
                if (key_star_s || key_hash_s) begin
                    code_buf_r <= {BUF_W{1'b0}};
                    digits_r   <= {DIG_W{1'b0}};
                    overflow_r <= 1'b0;
                end else if (key_alnum_s) begin
                    if (digits_r < DIG_FULL) begin
                        code_buf_r <= {code_buf_r[BUF_W-5:0], key_code};
                        digits_r   <= digits_r + DIG_W'(1);
                    end else begin
                        overflow_r <= 1'b1;
                    end
                end
            end else begin
                code_buf_r <= {BUF_W{1'b0}};
                digits_r   <= {DIG_W{1'b0}};
                overflow_r <= 1'b0;
            end

            // Retries survive walking away; only success or a served alarm restore them.
            if (submit_s) begin
                if (submit_ok_s)               tries_r <= TRY_MAX;
                else if (tries_r != {TRY_W{1'b0}}) tries_r <= tries_r - TRY_W'(1);
            end else if ((state_r == ST_ALARM) && timeout_s) begin
                tries_r <= TRY_MAX;
            end
        end
    end

    assign msg_id         = 3'(state_r);
    assign unlock         = (state_r == ST_OPEN) || (state_r == ST_DOOR_OPEN) || (state_r == ST_HELD);
    assign buzz           = (state_r == ST_ALARM);
    assign user_id        = user_id_r;
    assign digits_entered = digits_r;
    assign tries_left     = tries_r;

endmodule

// File: tb/tb_access_ctrl_fsm.sv
// Self-checking bench for access_ctrl_fsm with shortened timers
// (ENTRY_TIMEOUT=10, OPEN_TIME=10, ALARM_TIME=20).
module tb_access_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       presence = 1'b0;
    logic       reed_closed = 1'b1;
    logic       unlock;
    logic       buzz;
    logic [2:0] msg_id;
    logic [1:0] user_id;
    logic [2:0] digits_entered;
    logic [1:0] tries_left;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    access_ctrl_fsm #(
        .N_USERS       (4),
        .CODE_DIGITS   (4),
        .USER_CODES    (64'h0000_1234_4693_2580),
        .MAX_TRIES     (3),
        .ENTRY_TIMEOUT (10),
        .OPEN_TIME     (10),
        .ALARM_TIME    (20)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .presence       (presence),
        .reed_closed    (reed_closed),
        .unlock         (unlock),
        .buzz           (buzz),
        .msg_id         (msg_id),
        .user_id        (user_id),
        .digits_entered (digits_entered),
        .tries_left     (tries_left)
    );

`ifdef FORCED_ENTRY_ALARM_EN
    localparam logic [2:0] FORCED_MSG = 3'd5;
`else
    localparam logic [2:0] FORCED_MSG = 3'd0;
`endif

    typedef struct {
        logic       rst;
        logic       kv;
        logic [3:0] kc;
        logic       pres;
        logic       reed;
        logic [2:0] msg;
        logic [1:0] uid;
        logic [2:0] dig;
        logic [1:0] tries;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    // Expected output word; unlock/buzz follow from the expected state.
    function automatic logic [11:0] pack_exp(vec_t v);
        logic ul;
        logic bz;
        ul = (v.msg == 3'd3) || (v.msg == 3'd4) || (v.msg == 3'd6);
        bz = (v.msg == 3'd5);
        return {v.msg, ul, bz, v.uid, v.dig, v.tries};
    endfunction

    function automatic void add(logic rst, logic kv, logic [3:0] kc, logic pres, logic reed,
                                logic [2:0] msg, logic [1:0] uid, logic [2:0] dig, logic [1:0] tries);
        vec_t v;
        v.rst = rst; v.kv = kv; v.kc = kc; v.pres = pres; v.reed = reed;
        v.msg = msg; v.uid = uid; v.dig = dig; v.tries = tries;
        tbl.push_back(v);
    endfunction

    // Key press with a person present and the door closed.
    function automatic void key(logic [3:0] kc, logic [2:0] msg, logic [1:0] uid,
                                logic [2:0] dig, logic [1:0] tries);
        add(1'b1, 1'b1, kc, 1'b1, 1'b1, msg, uid, dig, tries);
    endfunction

    function automatic void nop(logic pres, logic reed, logic [2:0] msg, logic [1:0] uid,
                                logic [2:0] dig, logic [1:0] tries);
        add(1'b1, 1'b0, 4'h0, pres, reed, msg, uid, dig, tries);
    endfunction

    task automatic run_table(input string tag);
        vec_t        v;
        vec_t        e;
        logic [11:0] got;
        logic [11:0] want;
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            reset = v.rst; key_valid = v.kv; key_code = v.kc;
            presence = v.pres; reed_closed = v.reed;
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            e    = exp_q.pop_front();
            got  = {msg_id, unlock, buzz, user_id, digits_entered, tries_left};
            want = pack_exp(e);
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s[%0d]: got msg=%0d unlock=%b buzz=%b uid=%0d dig=%0d tries=%0d, want msg=%0d unlock=%b buzz=%b uid=%0d dig=%0d tries=%0d",
                         tag, i, got[11:9], got[8], got[7], got[6:5], got[4:2], got[1:0],
                         want[11:9], want[8], want[7], want[6:5], want[4:2], want[1:0]);
            end
        end
        tbl.delete();
        key_valid = 1'b0;
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Count consecutive cycles in state st (the current sample counts as one).
    task automatic stay_count(input logic [2:0] st, input logic pres, input logic reed,
                              input logic kv, input logic [3:0] kc, input int bound,
                              output int n);
        n = 1;
        key_valid = kv; key_code = kc; presence = pres; reed_closed = reed;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (msg_id == st) n++;
            else break;
        end
        key_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset, ignored profile keys, then user1 success with door cycle.
        add(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 3'd0, 2'd0, 3'd0, 2'd3);
        nop(1'b0, 1'b1, 3'd0, 2'd0, 3'd0, 2'd3);
        nop(1'b1, 1'b1, 3'd1, 2'd0, 3'd0, 2'd3);
        key(4'hE, 3'd1, 2'd0, 3'd0, 2'd3);
        key(4'h7, 3'd1, 2'd0, 3'd0, 2'd3);
        key(4'h1, 3'd1, 2'd1, 3'd0, 2'd3);
        key(4'hE, 3'd2, 2'd1, 3'd0, 2'd3);
        key(4'h4, 3'd2, 2'd1, 3'd1, 2'd3);
        key(4'h6, 3'd2, 2'd1, 3'd2, 2'd3);
        key(4'h9, 3'd2, 2'd1, 3'd3, 2'd3);
        key(4'h3, 3'd2, 2'd1, 3'd4, 2'd3);
        key(4'hE, 3'd3, 2'd1, 3'd0, 2'd3);
        nop(1'b1, 1'b0, 3'd4, 2'd1, 3'd0, 2'd3);
        nop(1'b0, 1'b1, 3'd0, 2'd1, 3'd0, 2'd3);
        nop(1'b0, 1'b1, 3'd0, 2'd1, 3'd0, 2'd3);
        run_table("user1");

        // Lockout: user0, three wrong submissions.
        nop(1'b1, 1'b1, 3'd1, 2'd1, 3'd0, 2'd3);
        key(4'h0, 3'd1, 2'd0, 3'd0, 2'd3);
        key(4'hE, 3'd2, 2'd0, 3'd0, 2'd3);
        for (int r = 0; r < 3; r++) begin
            for (int d = 1; d <= 4; d++) key(4'h1, 3'd2, 2'd0, 3'(d), 2'(3 - r));
            if (r < 2) key(4'hE, 3'd2, 2'd0, 3'd0, 2'(2 - r));
            else       key(4'hE, 3'd5, 2'd0, 3'd0, 2'd0);
        end
        run_table("lockout");
        stay_count(3'd5, 1'b1, 1'b1, 1'b1, 4'hE, 40, n);
        chk("alarm_len", n, 20);
        chk("alarm_exit_msg", int'(msg_id), 0);
        chk("alarm_exit_buzz", int'(buzz), 0);
        chk("alarm_exit_tries", int'(tries_left), 3);

        // user2: clear, overflow, presence loss, short code, then success; user3 0000.
        nop(1'b1, 1'b1, 3'd1, 2'd0, 3'd0, 2'd3);
        key(4'h2, 3'd1, 2'd2, 3'd0, 2'd3);
        key(4'hE, 3'd2, 2'd2, 3'd0, 2'd3);
        key(4'h1, 3'd2, 2'd2, 3'd1, 2'd3);
        key(4'h2, 3'd2, 2'd2, 3'd2, 2'd3);
        key(4'hF, 3'd2, 2'd2, 3'd0, 2'd3);
        for (int d = 1; d <= 4; d++) key(4'(d), 3'd2, 2'd2, 3'(d), 2'd3);
        key(4'hE, 3'd3, 2'd2, 3'd0, 2'd3);
        nop(1'b1, 1'b0, 3'd4, 2'd2, 3'd0, 2'd3);
        nop(1'b0, 1'b1, 3'd0, 2'd2, 3'd0, 2'd3);
        nop(1'b1, 1'b1, 3'd1, 2'd2, 3'd0, 2'd3);
        key(4'h2, 3'd1, 2'd2, 3'd0, 2'd3);
        key(4'hE, 3'd2, 2'd2, 3'd0, 2'd3);
        for (int d = 1; d <= 4; d++) key(4'(d), 3'd2, 2'd2, 3'(d), 2'd3);
        key(4'h5, 3'd2, 2'd2, 3'd4, 2'd3);
        key(4'hE, 3'd2, 2'd2, 3'd0, 2'd2);
        key(4'h1, 3'd2, 2'd2, 3'd1, 2'd2);
        nop(1'b0, 1'b1, 3'd0, 2'd2, 3'd0, 2'd2);
        nop(1'b1, 1'b1, 3'd1, 2'd2, 3'd0, 2'd2);
        key(4'h2, 3'd1, 2'd2, 3'd0, 2'd2);
        key(4'hE, 3'd2, 2'd2, 3'd0, 2'd2);
        for (int d = 1; d <= 3; d++) key(4'(d), 3'd2, 2'd2, 3'(d), 2'd2);
        key(4'hE, 3'd2, 2'd2, 3'd0, 2'd1);
        for (int d = 1; d <= 4; d++) key(4'(d), 3'd2, 2'd2, 3'(d), 2'd1);
        key(4'hE, 3'd3, 2'd2, 3'd0, 2'd3);
        nop(1'b1, 1'b0, 3'd4, 2'd2, 3'd0, 2'd3);
        nop(1'b0, 1'b1, 3'd0, 2'd2, 3'd0, 2'd3);
        nop(1'b1, 1'b1, 3'd1, 2'd2, 3'd0, 2'd3);
        key(4'h3, 3'd1, 2'd3, 3'd0, 2'd3);
        key(4'hE, 3'd2, 2'd3, 3'd0, 2'd3);
        for (int d = 1; d <= 4; d++) key(4'h0, 3'd2, 2'd3, 3'(d), 2'd3);
        key(4'hE, 3'd3, 2'd3, 3'd0, 2'd3);
        run_table("user2_user3");
        stay_count(3'd3, 1'b0, 1'b1, 1'b0, 4'h0, 40, n);
        chk("open_relock_len", n, 10);
        chk("open_relock_msg", int'(msg_id), 0);
        chk("open_relock_unlock", int'(unlock), 0);

        // Entry timeout in CODE, counted from the last key.
        nop(1'b1, 1'b1, 3'd1, 2'd3, 3'd0, 2'd3);
        key(4'h2, 3'd1, 2'd2, 3'd0, 2'd3);
        key(4'hE, 3'd2, 2'd2, 3'd0, 2'd3);
        key(4'h1, 3'd2, 2'd2, 3'd1, 2'd3);
        run_table("entry_to");
        stay_count(3'd2, 1'b1, 1'b1, 1'b0, 4'h0, 40, n);
        chk("entry_timeout_len", n, 10);
        chk("entry_timeout_msg", int'(msg_id), 0);
        chk("entry_timeout_digits", int'(digits_entered), 0);

        // Door held open -> HELD, then closed -> IDLE.
        nop(1'b1, 1'b1, 3'd1, 2'd2, 3'd0, 2'd3);
        key(4'h2, 3'd1, 2'd2, 3'd0, 2'd3);
        key(4'hE, 3'd2, 2'd2, 3'd0, 2'd3);
        for (int d = 1; d <= 4; d++) key(4'(d), 3'd2, 2'd2, 3'(d), 2'd3);
        key(4'hE, 3'd3, 2'd2, 3'd0, 2'd3);
        nop(1'b1, 1'b0, 3'd4, 2'd2, 3'd0, 2'd3);
        run_table("held_pre");
        stay_count(3'd4, 1'b1, 1'b0, 1'b0, 4'h0, 40, n);
        chk("door_open_len", n, 10);
        chk("held_msg", int'(msg_id), 6);
        chk("held_unlock", int'(unlock), 1);
        chk("held_buzz", int'(buzz), 0);
        nop(1'b1, 1'b0, 3'd6, 2'd2, 3'd0, 2'd3);
        nop(1'b0, 1'b1, 3'd0, 2'd2, 3'd0, 2'd3);

        // Reset in the middle of an alarm.
        nop(1'b1, 1'b1, 3'd1, 2'd2, 3'd0, 2'd3);
        key(4'h3, 3'd1, 2'd3, 3'd0, 2'd3);
        key(4'hE, 3'd2, 2'd3, 3'd0, 2'd3);
        key(4'hE, 3'd2, 2'd3, 3'd0, 2'd2);
        key(4'hE, 3'd2, 2'd3, 3'd0, 2'd1);
        key(4'hE, 3'd5, 2'd3, 3'd0, 2'd0);
        nop(1'b1, 1'b1, 3'd5, 2'd3, 3'd0, 2'd0);
        add(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 3'd0, 2'd0, 3'd0, 2'd3);
        nop(1'b0, 1'b1, 3'd0, 2'd0, 3'd0, 2'd3);

        // Door forced open while idle.
        nop(1'b0, 1'b0, FORCED_MSG, 2'd0, 3'd0, 2'd3);
        add(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 3'd0, 2'd0, 3'd0, 2'd3);
        run_table("held_reset_forced");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
